nx_ram_1rw_hw_client: RTL and testbench
=======================================

Name: nx_ram_1rw_hw_client

Overview:
- Hardware-side requester for the 1RW indirect-access RAM wrapper. It drives that wrapper's hw_* port and defers to software accesses via hw_yield.
- Accepts read/write requests from a datapath client over a valid/ready interface.
- Tracks reads in flight through the fixed RAM read latency and returns read data in order through a credit-protected response FIFO, so client backpressure never drops data.

Parameters:
- N_DATA_BITS, 38, RAM word width.
- N_ADDR_BITS, 14, RAM address width.
- RD_LATENCY, 2, cycles from a hw_cs read cycle to valid hw_dout (range 1..4).
- FIFO_DEPTH, 4, response FIFO entries; power of 2, at least RD_LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  N_ADDR_BITS  word address
- req_bwe  in  N_DATA_BITS  bit write enables (writes only)
- req_wdat  in  N_DATA_BITS  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts rsp_dat
- rsp_dat  out  N_DATA_BITS  read data, in request order
- hw_cs  out  1  RAM chip select
- hw_we  out  1  RAM write enable
- hw_add  out  N_ADDR_BITS  RAM address
- hw_bwe  out  N_DATA_BITS  RAM bit write enables
- hw_din  out  N_DATA_BITS  RAM write data
- hw_dout  in  N_DATA_BITS  RAM read data
- hw_yield  in  1  software access pending; hw must idle this cycle
- busy  out  1  read in flight or FIFO non-empty
- ovf_err  out  1  sticky: FIFO push while full (must never set)

Behaviour:
- Single clock domain. All state resets synchronously when rst is high at a clk edge.
- Reset values: rsp_valid 0, busy 0, ovf_err 0, FIFO empty, in-flight pipe cleared.
- Issue path is combinational from the request inputs:
  - req_ready = !rst && !hw_yield && (req_we || credit_ok).
  - credit_ok = (fifo_count + inflight_count) < FIFO_DEPTH.
  - hw_cs = req_valid && req_ready.
  - hw_we = req_we && hw_cs.
  - hw_add = req_addr, hw_bwe = req_bwe, hw_din = req_wdat.
  - When hw_cs is 0, hw_we, hw_bwe and hw_din are forced to 0.
- Writes consume no credit. A write is complete on acceptance and produces no response.
- hw_yield high forces hw_cs = 0 and req_ready = 0 in that cycle. A pending request holds its inputs stable (valid/ready rule) and issues on the first cycle hw_yield is low.
- In-flight tracking:
  - A RD_LATENCY-deep shift register of valid bits is loaded with (hw_cs && !hw_we) at each edge.
  - When the bit for cycle t is set, hw_dout is sampled at the edge ending cycle t+RD_LATENCY and pushed into the FIFO.
  - Read issued in cycle t → rsp_valid no earlier than cycle t+RD_LATENCY+1.
  - inflight_count = popcount of the shift register.
- Response FIFO:
  - Registered head; rsp_valid = !empty.
  - Pop = rsp_valid && rsp_ready. Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
  - With rsp_ready low, at most FIFO_DEPTH reads are outstanding, then req_ready drops for reads (writes still issue).
- Credit check counts in-flight reads, so a push never finds the FIFO full. A push while full sets ovf_err sticky until rst, and the data is dropped.
- Back-to-back reads: one per cycle when rsp_ready is held high and hw_yield is low, giving full throughput.
- busy = (inflight_count != 0) || (fifo_count != 0).
- Reset mid-operation discards in-flight reads and FIFO contents. No response is emitted for reads issued before reset.
- Ordering: responses leave in issue order. Writes and reads to the same address issue in acceptance order, so a read after a write returns the new data.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=1 → req_ready=0, hw_cs=0, rsp_valid=0, busy=0, ovf_err=0.
- Write then read: write addr 0x0010 data 0x2A_5A5A_5A5A with full bwe, then read 0x0010 with rsp_ready=1 → one hw_cs write, one hw_cs read; rsp_dat=0x2A_5A5A_5A5A exactly RD_LATENCY+1 cycles after the read issue.
- Yield stall: hw_yield=1 for cycles 5..7 with a read pending from cycle 5 → hw_cs=0 in cycles 5..7; issue in cycle 8 with req_addr unchanged.
- Backpressure: rsp_ready=0, 8 reads to addresses 0..7 → exactly 4 accepted, req_ready low afterwards. A write is still accepted. Raise rsp_ready → data for addresses 0,1,2,3 in order, then the remaining reads issue.
- Streaming: 16 consecutive reads with rsp_ready=1 → one hw_cs per cycle, 16 in-order responses, ovf_err stays 0.
- Reset mid-flight: 2 reads issued, rst asserted 1 cycle before the first data return → no rsp_valid after reset; busy=0 on the cycle after reset.

Source files
------------

// File: rtl/nx_ram_1rw_hw_client.sv
// nx_ram_1rw_hw_client
// Hardware-side requester for the 1RW indirect-access RAM wrapper.
// Issues client reads/writes on the hw_* port and stands aside whenever
// software holds hw_yield. Reads are tracked through the fixed RAM latency
// and returned in order from a small response FIFO. Read issue is gated by
// a credit check, so the FIFO always has room for every read in flight.

module nx_ram_1rw_hw_client #(
    parameter int N_DATA_BITS = 38,
    parameter int N_ADDR_BITS = 14,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [N_ADDR_BITS-1:0] req_addr,
    input  logic [N_DATA_BITS-1:0] req_bwe,
    input  logic [N_DATA_BITS-1:0] req_wdat,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [N_DATA_BITS-1:0] rsp_dat,
    output logic                   hw_cs,
    output logic                   hw_we,
    output logic [N_ADDR_BITS-1:0] hw_add,
    output logic [N_DATA_BITS-1:0] hw_bwe,
    output logic [N_DATA_BITS-1:0] hw_din,
    input  logic [N_DATA_BITS-1:0] hw_dout,
    input  logic                   hw_yield,
    output logic                   busy,
    output logic                   ovf_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // In-flight read tracking: bit k set means a read issued k+1 cycles ago
    logic [RD_LATENCY-1:0]  pipe_reg;
    logic [RD_LATENCY-1:0]  pipe_next;
    logic [CNT_W-1:0]       inflight_count;

    // Response FIFO state
    logic [N_DATA_BITS-1:0] fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       fifo_count_reg;
    logic [CNT_W-1:0]       fifo_count_next;
    logic                   ovf_err_reg;

    logic [CNT_W:0]         credit_sum;
    logic                   credit_ok;
    logic                   rd_issue;
    logic                   push;
    logic                   push_ok;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Advance a FIFO pointer with explicit wrap at FIFO_DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Count reads still travelling through the RAM pipeline
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_count = inflight_count + CNT_W'(pipe_reg[i]);
        end
    end

    // Issue path: combinational from the request, gated by yield and read credit
    always_comb begin
        credit_sum = {1'b0, fifo_count_reg} + {1'b0, inflight_count};
        credit_ok  = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);
        req_ready  = !rst && !hw_yield && (req_we || credit_ok);
        hw_cs      = req_valid && req_ready;
        hw_we      = hw_cs && req_we;
        hw_add     = req_addr;
        hw_bwe     = hw_cs ? req_bwe  : '0;
        hw_din     = hw_cs ? req_wdat : '0;
        rd_issue   = hw_cs && !req_we;
    end

    // Shift chain feeding each stage from the one before it
    assign pipe_next[0] = rd_issue;
    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    endgenerate

    // In-flight valid-bit pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= pipe_next;
        end
    end

    // FIFO handshakes: a read leaving the pipe delivers hw_dout this edge
    always_comb begin
        fifo_empty = (fifo_count_reg == '0);
        fifo_full  = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
        push       = pipe_reg[RD_LATENCY-1];
        push_ok    = push && !fifo_full;
        pop        = !fifo_empty && rsp_ready;
    end

    // Occupancy update; a simultaneous push and pop cancel out
    always_comb begin
        fifo_count_next = fifo_count_reg;
        case ({push_ok, pop})
            2'b10:   fifo_count_next = fifo_count_reg + CNT_W'(1);
            2'b01:   fifo_count_next = fifo_count_reg - CNT_W'(1);
            default: fifo_count_next = fifo_count_reg;
        endcase
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            ovf_err_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            fifo_count_reg <= fifo_count_next;
            if (push && fifo_full) begin
                ovf_err_reg <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= hw_dout;
        end
    end

    // Response and status outputs
    always_comb begin
        rsp_valid = !fifo_empty;
        rsp_dat   = fifo_mem[rd_ptr_reg];
        busy      = (inflight_count != '0) || (fifo_count_reg != '0);
        ovf_err   = ovf_err_reg;
    end

endmodule

// File: tb/tb_nx_ram_1rw_hw_client.sv
// tb_nx_ram_1rw_hw_client
// Directed bench: a behavioural 2-cycle-latency RAM answers the hw_* port,
// and a linear sequence of steps checks issue, latency, yield, credit
// backpressure, streaming and mid-flight reset against hand-computed values.

module tb_nx_ram_1rw_hw_client;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [37:0] req_bwe;
    logic [37:0] req_wdat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [37:0] rsp_dat;
    logic        hw_cs;
    logic        hw_we;
    logic [13:0] hw_add;
    logic [37:0] hw_bwe;
    logic [37:0] hw_din;
    logic [37:0] hw_dout;
    logic        hw_yield;
    logic        busy;
    logic        ovf_err;

    int checks = 0;
    int passed = 0;

    nx_ram_1rw_hw_client #(
        .N_DATA_BITS(38),
        .N_ADDR_BITS(14),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_bwe  (req_bwe),
        .req_wdat (req_wdat),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .hw_cs    (hw_cs),
        .hw_we    (hw_we),
        .hw_add   (hw_add),
        .hw_bwe   (hw_bwe),
        .hw_din   (hw_din),
        .hw_dout  (hw_dout),
        .hw_yield (hw_yield),
        .busy     (busy),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: bit-masked writes, read data valid two cycles after issue
    logic [37:0] ram [0:16383];
    logic [37:0] rd_s1;
    int          n_wr = 0;
    int          n_rd = 0;

    always @(posedge clk) begin
        if (hw_cs && hw_we) begin
            ram[hw_add] <= (ram[hw_add] & ~hw_bwe) | (hw_din & hw_bwe);
        end
        rd_s1   <= ram[hw_add];
        hw_dout <= rd_s1;
        if (hw_cs && hw_we)  n_wr <= n_wr + 1;
        if (hw_cs && !hw_we) n_rd <= n_rd + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [37:0] got [0:15];
        int          acc;
        int          nrsp;
        int          issued;
        logic        accepted;

        for (int i = 0; i < 16384; i++) begin
            ram[i] <= 38'h30_0000_0000 | 38'(i);
        end
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        req_bwe   = '0;
        req_wdat  = '0;
        rsp_ready = 1'b0;
        hw_yield  = 1'b0;

        // Reset held 3 cycles with a request present
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_hw_cs", hw_cs, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ovf_err", ovf_err, 0);
            $display("reset cycle %0d: req_ready=%0b hw_cs=%0b", c, req_ready, hw_cs);
            cyc();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();

        // Write 0x10, then read it back
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 14'h0010;
        req_bwe   = '1;
        req_wdat  = 38'h2A_5A5A_5A5A;
        @(negedge clk);
        chk("wr_hw_cs", hw_cs, 1);
        chk("wr_hw_we", hw_we, 1);
        chk("wr_hw_add", hw_add, 14'h0010);
        chk("wr_hw_din", hw_din, 38'h2A_5A5A_5A5A);
        $display("write addr=0x%0h data=0x%0h", hw_add, hw_din);
        cyc();
        req_we   = 1'b0;
        req_bwe  = '0;
        req_wdat = '0;
        @(negedge clk);
        chk("rd_hw_cs", hw_cs, 1);
        chk("rd_hw_we", hw_we, 0);
        chk("rd_hw_din_forced", hw_din, 0);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_lat1_valid", rsp_valid, 0);
        chk("rd_lat1_busy", busy, 1);
        cyc();
        @(negedge clk);
        chk("rd_lat2_valid", rsp_valid, 0);
        cyc();
        @(negedge clk);
        chk("rd_lat3_valid", rsp_valid, 1);
        chk("rd_lat3_data", rsp_dat, 38'h2A_5A5A_5A5A);
        $display("read addr=0x10 data=0x%0h", rsp_dat);
        cyc();
        @(negedge clk);
        chk("rd_drained_valid", rsp_valid, 0);
        chk("rd_drained_busy", busy, 0);
        chk("rd_n_wr", n_wr, 1);
        chk("rd_n_rd", n_rd, 1);

        // Yield stall: read pending for 3 yield cycles, issues on the 4th
        cyc();
        hw_yield  = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 14'h0005;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("yield_hw_cs", hw_cs, 0);
            chk("yield_req_ready", req_ready, 0);
            cyc();
        end
        hw_yield = 1'b0;
        @(negedge clk);
        chk("yield_issue_cs", hw_cs, 1);
        chk("yield_issue_add", hw_add, 14'h0005);
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("yield_rsp_valid", rsp_valid, 1);
        chk("yield_rsp_dat", rsp_dat, 38'h30_0000_0005);
        $display("yield read addr=0x5 data=0x%0h", rsp_dat);
        cyc();

        // Backpressure: rsp_ready low, reads 0..7 offered for 8 cycles
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 14'h0000;
        acc       = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            accepted = req_valid && req_ready;
            cyc();
            if (accepted) begin
                acc++;
                req_addr = 14'(acc);
            end
        end
        chk("bp_accepted", acc, 4);
        @(negedge clk);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_head_valid", rsp_valid, 1);
        chk("bp_head_dat", rsp_dat, 38'h30_0000_0000);
        $display("backpressure accepted=%0d head=0x%0h", acc, rsp_dat);
        cyc();
        req_we   = 1'b1;
        req_addr = 14'h0020;
        req_bwe  = '1;
        req_wdat = 38'h00_0000_0011;
        @(negedge clk);
        chk("bp_wr_ready", req_ready, 1);
        chk("bp_wr_cs", hw_cs, 1);
        cyc();
        req_we   = 1'b0;
        req_addr = 14'(acc);
        req_bwe  = '0;
        req_wdat = '0;
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got[nrsp] = rsp_dat;
                $display("bp response %0d data=0x%0h", nrsp, rsp_dat);
                nrsp++;
            end
            accepted = req_valid && req_ready;
            cyc();
            if (accepted) begin
                acc++;
                if (acc == 8) req_valid = 1'b0;
                else          req_addr  = 14'(acc);
            end
        end
        chk("bp_nrsp", nrsp, 8);
        for (int i = 0; i < 8; i++) begin
            chk("bp_order", got[i], 38'h30_0000_0000 + 38'(i));
        end
        chk("bp_ovf_err", ovf_err, 0);

        // Streaming: 16 back-to-back reads from 0x100 with rsp_ready high
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 14'h0100;
        issued    = 0;
        nrsp      = 0;
        for (int c = 0; c < 60 && nrsp < 16; c++) begin
            @(negedge clk);
            if (issued < 16) chk("st_hw_cs", hw_cs, 1);
            if (rsp_valid) begin
                got[nrsp] = rsp_dat;
                $display("stream response %0d data=0x%0h", nrsp, rsp_dat);
                nrsp++;
            end
            accepted = hw_cs;
            cyc();
            if (accepted) begin
                issued++;
                if (issued == 16) req_valid = 1'b0;
                else              req_addr  = 14'h0100 + 14'(issued);
            end
        end
        chk("st_nrsp", nrsp, 16);
        for (int i = 0; i < 16; i++) begin
            chk("st_order", got[i], 38'h30_0000_0100 + 38'(i));
        end
        @(negedge clk);
        chk("st_ovf_err", ovf_err, 0);
        chk("st_idle_busy", busy, 0);
        cyc();

        // Reset mid-flight: two reads, rst during the cycle before first return
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 14'h0000;
        @(negedge clk);
        chk("mf_cs0", hw_cs, 1);
        cyc();
        req_addr = 14'h0001;
        @(negedge clk);
        chk("mf_cs1", hw_cs, 1);
        cyc();
        req_valid = 1'b0;
        rst       = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mf_busy", busy, 0);
        chk("mf_rsp_valid", rsp_valid, 0);
        $display("mid-flight reset: busy=%0b rsp_valid=%0b", busy, rsp_valid);
        for (int c = 0; c < 4; c++) begin
            cyc();
            @(negedge clk);
            chk("mf_no_rsp", rsp_valid, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
